// File: rtl/mem_stage_pipe_if.sv
// EX -> MEM bus of mem_stage_pipe: EX-slot inputs flow to the stage, MEM-stage results flow back.
// master = upstream driver of the EX slot, slave = the memory stage.
interface mem_stage_pipe_if #(
  parameter int REG_AW = 5
);
  logic              ex_valid;
  logic [REG_AW-1:0] ex_destR;
  logic [31:0]       ex_aluR;
  logic [31:0]       ex_inB;
  logic              ex_wreg;
  logic              ex_m2reg;
  logic              ex_wmem;
  logic [1:0]        ex_size;
  logic              ex_unsigned;
  logic [3:0]        EXE_ins_type;
  logic [3:0]        EXE_ins_number;

  logic              mem_stall;
  logic              mem_valid;
  logic              mem_wreg;
  logic              mem_m2reg;
  logic [31:0]       mem_aluR;
  logic [REG_AW-1:0] mem_destR;
  logic [31:0]       mem_mdata;
  logic              mem_misalign;
  logic [3:0]        MEM_ins_type;
  logic [3:0]        MEM_ins_number;

  modport master (
    output ex_valid, ex_destR, ex_aluR, ex_inB, ex_wreg, ex_m2reg, ex_wmem,
           ex_size, ex_unsigned, EXE_ins_type, EXE_ins_number,
    input  mem_stall, mem_valid, mem_wreg, mem_m2reg, mem_aluR, mem_destR,
           mem_mdata, mem_misalign, MEM_ins_type, MEM_ins_number
  );

  modport slave (
    input  ex_valid, ex_destR, ex_aluR, ex_inB, ex_wreg, ex_m2reg, ex_wmem,
           ex_size, ex_unsigned, EXE_ins_type, EXE_ins_number,
    output mem_stall, mem_valid, mem_wreg, mem_m2reg, mem_aluR, mem_destR,
           mem_mdata, mem_misalign, MEM_ins_type, MEM_ins_number
  );
endinterface

// File: rtl/mem_stage_pipe.sv
// MEM pipeline stage: EX/MEM register, byte-lane data memory, sized loads/stores and a load wait-state FSM.
// Optional MEM_MISALIGN_TRAP_EN flags misaligned accesses instead of forcing alignment.
module mem_stage_pipe #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 0,
  parameter int REG_AW      = 5
) (
  input  logic            clk,
  input  logic            rst,
  mem_stage_pipe_if.slave bus
);

  localparam int         DEPTH   = 1 << ADDR_W;
  localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_next;

  logic              r_valid;
  logic              r_wreg;
  logic              r_m2reg;
  logic              r_wmem;
  logic              r_unsigned;
  logic [1:0]        r_size;
  logic [REG_AW-1:0] r_destR;
  logic [31:0]       r_aluR;
  logic [31:0]       r_inB;
  logic [3:0]        r_ins_type;
  logic [3:0]        r_ins_number;

  logic              w_stall;
  logic              w_out_valid;
  logic              w_cap_load;
  logic              w_ex_mis;
  logic              w_mis;
  logic              w_we;
  logic [ADDR_W-1:0] w_idx;
  logic [1:0]        w_lo;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [31:0]       w_rword;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_ext;

`ifdef MEM_MISALIGN_TRAP_EN
  function automatic logic f_misalign(input logic [1:0] size, input logic [1:0] lo);
    return ((size == 2'b01) && lo[0]) || (size[1] && (lo != 2'b00));
  endfunction

  assign w_ex_mis = f_misalign(bus.ex_size, bus.ex_aluR[1:0]);
  assign w_mis    = r_valid & (r_m2reg | r_wmem) & f_misalign(r_size, r_aluR[1:0]);
`else
  assign w_ex_mis = 1'b0;
  assign w_mis    = 1'b0;
`endif

  // A misaligned load is trapped, so it never enters the wait states.
  assign w_cap_load = bus.ex_valid & bus.ex_m2reg & ~w_ex_mis;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_wreg       <= 1'b0;
      r_m2reg      <= 1'b0;
      r_wmem       <= 1'b0;
      r_unsigned   <= 1'b0;
      r_size       <= 2'b00;
      r_destR      <= '0;
      r_aluR       <= 32'h0;
      r_inB        <= 32'h0;
      r_ins_type   <= 4'h0;
      r_ins_number <= 4'h0;
    end else if (!w_stall) begin
      r_valid      <= bus.ex_valid;
      r_wreg       <= bus.ex_valid & bus.ex_wreg;
      r_m2reg      <= bus.ex_valid & bus.ex_m2reg;
      r_wmem       <= bus.ex_valid & bus.ex_wmem;
      r_unsigned   <= bus.ex_unsigned;
      r_size       <= bus.ex_size;
      r_destR      <= bus.ex_destR;
      r_aluR       <= bus.ex_aluR;
      r_inB        <= bus.ex_inB;
      r_ins_type   <= bus.EXE_ins_type;
      r_ins_number <= bus.EXE_ins_number;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_stall      = 1'b0;
    case (r_state)
      S_WAIT: begin
        w_stall = 1'b1;
        if (r_cnt <= 4'd1) begin
          w_state_next = S_DONE;
          w_cnt_next   = 4'd0;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      default: begin
        // IDLE and DONE both accept a new instruction at the closing edge.
        if (w_cap_load && (LP_WAIT != 4'd0)) begin
          w_state_next = S_WAIT;
          w_cnt_next   = LP_WAIT;
        end else begin
          w_state_next = S_IDLE;
          w_cnt_next   = 4'd0;
        end
      end
    endcase
  end

  assign w_idx = r_aluR[ADDR_W+1:2];
  assign w_lo  = r_aluR[1:0];

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = r_inB;
    case (r_size)
      2'b00: begin
        w_be    = 4'b0001 << w_lo;
        w_wdata = {4{r_inB[7:0]}};
      end
      2'b01: begin
        w_be    = w_lo[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{r_inB[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = r_inB;
      end
    endcase
  end

  // Stores never stall, so any non-stalled cycle holding a store is its first.
  assign w_we = r_wmem & ~w_stall & ~w_mis;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] r_lane [DEPTH];

      always_ff @(posedge clk) begin
        if (w_we && w_be[gi]) begin
          r_lane[w_idx] <= w_wdata[8*gi +: 8];
        end
      end

      assign w_rword[8*gi +: 8] = r_lane[w_idx];
    end
  endgenerate

  assign w_byte = w_rword[{w_lo, 3'b000} +: 8];
  assign w_half = w_lo[1] ? w_rword[31:16] : w_rword[15:0];

  always_comb begin
    w_ext = w_rword;
    case (r_size)
      2'b00:   w_ext = r_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_ext = r_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_ext = w_rword;
    endcase
  end

  assign w_out_valid = r_valid & (r_state != S_WAIT);

  assign bus.mem_stall      = w_stall;
  assign bus.mem_valid      = w_out_valid;
  assign bus.mem_wreg       = r_wreg & w_out_valid & ~(r_m2reg & w_mis);
  assign bus.mem_m2reg      = r_m2reg & w_out_valid;
  assign bus.mem_aluR       = r_aluR;
  assign bus.mem_destR      = r_destR;
  assign bus.mem_mdata      = (r_m2reg && !w_mis) ? w_ext : 32'h0;
  assign bus.mem_misalign   = w_mis & w_out_valid;
  assign bus.MEM_ins_type   = r_ins_type;
  assign bus.MEM_ins_number = r_ins_number;

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Bench for mem_stage_pipe: directed steps then random traffic checked against a byte-addressed memory model.
// Expectations follow MEM_MISALIGN_TRAP_EN when it is defined for the build.
module tb_mem_stage_pipe;
  localparam int ADDR_W      = 8;
  localparam int WAIT_CYCLES = 3;
  localparam int REG_AW      = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_stage_pipe_if #(.REG_AW(REG_AW)) bus ();

  mem_stage_pipe #(
    .ADDR_W     (ADDR_W),
    .WAIT_CYCLES(WAIT_CYCLES),
    .REG_AW     (REG_AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] mem_m [0:1023];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_stall"},  32'(bus.mem_stall), 32'h0);
    chk({tag, "_valid"},  32'(bus.mem_valid), 32'h0);
    chk({tag, "_wreg"},   32'(bus.mem_wreg), 32'h0);
    chk({tag, "_m2reg"},  32'(bus.mem_m2reg), 32'h0);
    chk({tag, "_aluR"},   bus.mem_aluR, 32'h0);
    chk({tag, "_destR"},  32'(bus.mem_destR), 32'h0);
    chk({tag, "_mdata"},  bus.mem_mdata, 32'h0);
    chk({tag, "_mis"},    32'(bus.mem_misalign), 32'h0);
    chk({tag, "_itype"},  32'(bus.MEM_ins_type), 32'h0);
    chk({tag, "_inum"},   32'(bus.MEM_ins_number), 32'h0);
  endtask

  task automatic drive_bubble();
    bus.ex_valid       = 1'b0;
    bus.ex_destR       = '0;
    bus.ex_aluR        = 32'h0;
    bus.ex_inB         = 32'h0;
    bus.ex_wreg        = 1'b0;
    bus.ex_m2reg       = 1'b0;
    bus.ex_wmem        = 1'b0;
    bus.ex_size        = 2'b00;
    bus.ex_unsigned    = 1'b0;
    bus.EXE_ins_type   = 4'h0;
    bus.EXE_ins_number = 4'h0;
  endtask

  // Called at a negedge; returns at the negedge of the instruction's result cycle.
  task automatic send(input logic v, input logic w, input logic m2, input logic wm,
                      input logic [1:0] sz, input logic un, input logic [31:0] a,
                      input logic [31:0] d, input logic [REG_AW-1:0] dst);
    logic [3:0]  ty, nu;
    logic [31:0] raw, exp_md;
    int n, ai, base, st, exp_st;
    bit mis, trap;
    ty = 4'($urandom);
    nu = 4'($urandom);
    n    = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    ai   = int'(a[9:0]);
    base = ai - (ai % n);
    mis  = (ai % n) != 0;
`ifdef MEM_MISALIGN_TRAP_EN
    trap = mis && v && (m2 || wm);
`else
    trap = 1'b0;
`endif
    exp_md = 32'h0;
    raw    = 32'h0;
    if (v && m2 && !trap) begin
      for (int i = 0; i < n; i++) raw[8*i +: 8] = mem_m[base + i];
      case (n)
        1:       exp_md = un ? {24'h0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
        2:       exp_md = un ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
        default: exp_md = raw;
      endcase
    end
    if (v && wm && !trap) begin
      for (int i = 0; i < n; i++) mem_m[base + i] = d[8*i +: 8];
    end
    exp_st = (v && m2 && !trap) ? WAIT_CYCLES : 0;

    bus.ex_valid = v;   bus.ex_wreg = w;  bus.ex_m2reg = m2; bus.ex_wmem = wm;
    bus.ex_size = sz;   bus.ex_unsigned = un; bus.ex_aluR = a; bus.ex_inB = d;
    bus.ex_destR = dst; bus.EXE_ins_type = ty; bus.EXE_ins_number = nu;
    @(posedge clk);
    @(negedge clk);
    st = 0;
    while (bus.mem_stall && st < 40) begin
      chk("stall_valid", 32'(bus.mem_valid), 32'h0);
      chk("hold_aluR", bus.mem_aluR, a);
      chk("hold_destR", 32'(bus.mem_destR), 32'(dst));
      bus.ex_valid = 1'b1; bus.ex_m2reg = 1'($urandom); bus.ex_wmem = 1'($urandom);
      bus.ex_aluR = $urandom; bus.ex_destR = REG_AW'($urandom); bus.ex_inB = $urandom;
      st++;
      @(negedge clk);
    end
    chk("stall_cycles", 32'(st), 32'(exp_st));
    chk("valid", 32'(bus.mem_valid), 32'(v));
    chk("wreg", 32'(bus.mem_wreg), 32'(v && w && !(m2 && trap)));
    chk("m2reg", 32'(bus.mem_m2reg), 32'(v && m2));
    chk("aluR", bus.mem_aluR, a);
    chk("destR", 32'(bus.mem_destR), 32'(dst));
    chk("mdata", bus.mem_mdata, exp_md);
    chk("misalign", 32'(bus.mem_misalign), 32'(trap));
    chk("itype", 32'(bus.MEM_ins_type), 32'(ty));
    chk("inum", 32'(bus.MEM_ins_number), 32'(nu));
    $display("op v=%0d w=%0d ld=%0d st=%0d sz=%0d u=%0d addr=%08h data=%08h mdata=%08h stalls=%0d",
             v, w, m2, wm, sz, un, a, d, bus.mem_mdata, st);
  endtask

  task automatic load(input logic [1:0] sz, input logic un, input logic [31:0] a);
    send(1'b1, 1'b1, 1'b1, 1'b0, sz, un, a, $urandom, REG_AW'($urandom));
  endtask

  task automatic store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    send(1'b1, 1'b0, 1'b0, 1'b1, sz, 1'b0, a, d, REG_AW'($urandom));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int kind;
    drive_bubble();
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // directed memory behaviour
    store(2'b10, 32'h10, 32'hDEADBEEF);
    load(2'b10, 1'b0, 32'h10);
    chk("word_load_const", bus.mem_mdata, 32'hDEADBEEF);
    load(2'b00, 1'b0, 32'h13);
    chk("byte_s_const", bus.mem_mdata, 32'hFFFFFFDE);
    load(2'b00, 1'b1, 32'h13);
    chk("byte_u_const", bus.mem_mdata, 32'h000000DE);
    load(2'b01, 1'b0, 32'h10);
    chk("half_s_const", bus.mem_mdata, 32'hFFFFBEEF);
    store(2'b00, 32'h11, 32'hABCD1255);
    load(2'b10, 1'b0, 32'h10);
    chk("byte_store_const", bus.mem_mdata, 32'hDEAD55EF);
    load(2'b01, 1'b0, 32'h11);
    send(1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'h12345678, 5'd7);
    store(2'b01, 32'h22, 32'hCAFE8001);
    load(2'b01, 1'b1, 32'h22);

    // reset in the second wait cycle of a load
    bus.ex_valid = 1'b1; bus.ex_wreg = 1'b1; bus.ex_m2reg = 1'b1; bus.ex_wmem = 1'b0;
    bus.ex_size = 2'b10; bus.ex_aluR = 32'h10; bus.ex_destR = 5'd3;
    bus.EXE_ins_type = 4'h5; bus.EXE_ins_number = 4'h9;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("rst_pre_stall", 32'(bus.mem_stall), 32'h1);
    rst = 1'b1;
    #1;
    chk_zero("rst_wait");
    drive_bubble();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    load(2'b10, 1'b0, 32'h10);
    chk("mem_kept_const", bus.mem_mdata, 32'hDEAD55EF);

    // fill the random window, leaving word 0x10 untouched
    for (int i = 0; i < 16; i++) begin
      if (i != 4) store(2'b10, 32'(4 * i), $urandom);
    end

    // random traffic
    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: load(2'($urandom), 1'($urandom), 32'($urandom_range(0, 63)));
        1: store(2'($urandom), 32'($urandom_range(0, 63)), $urandom);
        2: send(1'b1, 1'b1, 1'b0, 1'b0, 2'($urandom), 1'($urandom), $urandom, $urandom,
                REG_AW'($urandom));
        default: send(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
                      1'($urandom), 32'($urandom_range(0, 63)), $urandom, REG_AW'($urandom));
      endcase
    end

    drive_bubble();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_stage_pipe.md
# mem_stage_pipe

Parametrised memory-access pipeline stage. It holds the EX/MEM pipeline register and a local data memory, and supports byte, half and word loads and stores with sign or zero extension. A configurable load latency is handled by a wait-state FSM that raises a stall to the upstream pipeline. It sits between the execute stage and the write-back stage of the pipelined CPU and drives the MEM-stage outputs consumed by write-back and by the forwarding logic.

## Interface
Parameters:
- ADDR_W, 8, word-address width; memory depth is 2**ADDR_W 32-bit words.
- WAIT_CYCLES, 0, extra cycles a load spends in the stage (0..15).
- REG_AW, 5, destination register index width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- ex_valid  in  1  EX slot holds a real instruction; 0 = bubble.
- ex_destR  in  REG_AW  destination register.
- ex_aluR  in  32  ALU result or effective address.
- ex_inB  in  32  store data.
- ex_wreg, ex_m2reg, ex_wmem  in  1 each  register write, load select, store.
- ex_size  in  2  access size: 00 byte, 01 half, 10 word (11 treated as word).
- ex_unsigned  in  1  zero-extend loads when 1.
- EXE_ins_type, EXE_ins_number  in  4 each  debug tags, passed through.
- mem_stall  out  1  freeze EX and earlier stages while high.
- mem_valid  out  1  MEM outputs are a completed instruction.
- mem_wreg, mem_m2reg  out  1 each  registered controls; both gated by mem_valid.
- mem_aluR  out  32  registered ALU result.
- mem_destR  out  REG_AW  registered destination.
- mem_mdata  out  32  extended load data.
- mem_misalign  out  1  misaligned access flag.
- MEM_ins_type, MEM_ins_number  out  4 each  registered debug tags.

## Operation
- Pipeline register: loads all ex_* inputs on a rising edge when mem_stall=0 and holds them when mem_stall=1.
- Bubble: ex_valid=0 captures wreg, m2reg and wmem as 0.
- Word index is aluR[ADDR_W+1:2]. Lane selection uses aluR[1:0].
- Store: committed at the end of the first cycle the instruction occupies the stage.
  - Byte enables: byte → one lane at aluR[1:0]; half → lanes {aluR[1],0}+{0,1}; word → all four lanes.
  - Store data is replicated across lanes (byte ×4, half ×2).
  - Stores never stall.
- Load: asynchronous array read. The selected byte or half is right-justified, then sign-extended (ex_unsigned=0) or zero-extended.
- Non-load instructions drive mem_mdata = 0.
- FSM states:
  - IDLE: if a load is captured and WAIT_CYCLES>0, go to WAIT and set cnt=WAIT_CYCLES.
  - WAIT: mem_stall=1 and mem_valid=0; cnt decrements each cycle; when cnt reaches 1, go to DONE.
  - DONE: mem_stall=0 and mem_valid=1 for one cycle; return to IDLE, or go straight back to WAIT if the next captured instruction is a load.
- Memory contents are not cleared by reset.

## Timing
- Capture at edge k makes the result visible in cycle k+1.
  - Non-load, or load with WAIT_CYCLES=0: mem_valid=1 in cycle k+1.
  - Load with WAIT_CYCLES=N>0: mem_stall=1 in cycles k+1..k+N; result with mem_valid=1 in cycle k+N+1.
- Throughput: one instruction per cycle except loads, which take N+1 cycles each.
- Back-to-back loads: the second load is captured at the edge ending the first load's DONE cycle.
- Reset (including during WAIT): FSM returns to IDLE, cnt=0, and every output goes to 0 (mem_stall, mem_valid, mem_wreg, mem_m2reg, mem_aluR, mem_destR, mem_mdata, mem_misalign, and the tags).
- Store followed by a load to the same word in the next cycle: the load returns the new data.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - Misaligned means half with aluR[0]=1, or word with aluR[1:0]≠0.
  - A misaligned access sets mem_misalign=1 for its result cycle.
  - A misaligned store is suppressed.
  - A misaligned load returns 0, forces mem_wreg=0 and takes no wait states.
- MEM_MISALIGN_TRAP_EN undefined:
  - mem_misalign is tied to 0.
  - Halves ignore aluR[0]; words ignore aluR[1:0] (forced alignment).

## Test plan
- Word store 0xDEADBEEF @0x10, then word load @0x10 → mem_mdata=0xDEADBEEF with mem_m2reg=1.
- Byte load @0x13 after that store, unsigned=0 → 0xFFFFFFDE; unsigned=1 → 0x000000DE. Half load @0x10 → 0xFFFFBEEF.
- WAIT_CYCLES=3, two consecutive loads → mem_stall high for 3 cycles before each result; mem_valid pulses once per load; EX input is held during the stall.
- Byte store 0x55 @0x11 onto 0xDEADBEEF → word @0x10 reads 0xDEAD55EF.
- Half load @0x11 → with MEM_MISALIGN_TRAP_EN: mem_misalign=1, mem_wreg=0, mem_mdata=0; without it: data from @0x10.
- rst asserted in the 2nd WAIT cycle → all outputs 0 immediately; after release, the memory still holds 0xDEAD55EF @0x10.
